// File: rtl/affine_addr_gen.sv
// affine_addr_gen: DIMS-deep affine address walker; start/offset/extent/stride config in, addr_out/addr_valid/addr_ready/addr_last handshake out, busy/done status
module affine_addr_gen #(
  parameter int WIDTH = 16,
  parameter int DIMS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      offset,
  input  logic [DIMS*WIDTH-1:0] extent,
  input  logic [DIMS*WIDTH-1:0] stride,
  output logic [WIDTH-1:0]      addr_out,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, step;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, carry, any_zero;
  logic [DIMS-1:0][WIDTH-1:0] idx_q, idx_d, ext_q, ext_d, str_q, str_d;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    idx_d    = idx_q;
    ext_d    = ext_q;
    str_d    = str_q;
    step     = '0;
    carry    = 1'b1;
    any_zero = 1'b0;
    for (int d = 0; d < DIMS; d++) any_zero |= (extent[d*WIDTH +: WIDTH] == '0);
    if (state_q == IDLE && start) begin
      ext_d   = extent;
      str_d   = stride;
      idx_d   = '0;
      state_d = any_zero ? FINISH : RUN;
      valid_d = !any_zero;
      done_d  = any_zero;
      addr_d  = any_zero ? addr_q : offset;
    end else if (state_q == RUN && valid_q && addr_ready) begin
      // ripple the carry upward; the first dimension that absorbs it supplies the jump
      for (int d = 0; d < DIMS; d++) begin
        if (carry) begin
          if (idx_q[d] == ext_q[d] - WIDTH'(1)) begin
            idx_d[d] = '0;
          end else begin
            idx_d[d] = idx_q[d] + WIDTH'(1);
            step     = str_q[d];
            carry    = 1'b0;
          end
        end
      end
      state_d = carry ? FINISH : RUN;
      valid_d = !carry;
      done_d  = carry;
      addr_d  = addr_q + step;
    end else if (state_q == FINISH) begin
      state_d = IDLE;
    end
    last_d = valid_d;
    for (int d = 0; d < DIMS; d++) last_d &= (idx_d[d] == ext_d[d] - WIDTH'(1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      ext_q   <= '0;
      str_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      ext_q   <= ext_d;
      str_q   <= str_d;
    end
  end
  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign addr_last  = last_q;
  assign done       = done_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_affine_addr_gen.sv
// tb_affine_addr_gen: randomized and directed checks of affine_addr_gen against a mixed-radix counting model
module tb_affine_addr_gen;
  localparam int W = 16;
  localparam int D = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, addr_ready = 1'b0;
  logic [W-1:0] offset = '0;
  logic [D*W-1:0] extent = '0, stride = '0;
  logic [W-1:0] addr_out;
  logic addr_valid, addr_last, busy, done;
  int errors = 0, checks = 0;
  int m_ext[D];
  logic [W-1:0] m_str[D];
  logic [W-1:0] m_off;
  logic [W-1:0] exp_q[$];

  affine_addr_gen #(.WIDTH(W), .DIMS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .offset(offset), .extent(extent), .stride(stride),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_last(addr_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // element k of the walk is the mixed-radix number k; the jump into k+1 comes
  // from the lowest digit of k that is not at its maximum
  function automatic void model();
    int total, r, h;
    logic [W-1:0] a;
    a = m_off;
    total = 1;
    exp_q.delete();
    for (int i = 0; i < D; i++) total *= m_ext[i];
    for (int k = 0; k < total; k++) begin
      exp_q.push_back(a);
      r = k;
      h = 0;
      while (h < D && r % m_ext[h] == m_ext[h] - 1) begin
        r = r / m_ext[h];
        h++;
      end
      if (h < D) a = a + m_str[h];
    end
  endfunction

  task automatic rand_cfg();
    m_off = W'($urandom);
    for (int i = 0; i < D; i++) begin
      m_ext[i] = $urandom_range(1, 4);
      m_str[i] = W'($urandom);
    end
  endtask

  task automatic walk(input string name, input bit rnd_ready, input bit poke, input int bp_at);
    int n, cyc, hold, total;
    n = 0; cyc = 0; hold = 0;
    model();
    total = exp_q.size();
    offset = m_off;
    for (int i = 0; i < D; i++) begin
      extent[i*W +: W] = W'(m_ext[i]);
      stride[i*W +: W] = m_str[i];
    end
    start = 1'b1;
    addr_ready = 1'b0;
    step();
    start = 1'b0;
    if (total == 0) begin
      checks++;
      if (addr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s zero_extent: valid=%b done=%b busy=%b, want 0 1 1", name, addr_valid, done, busy);
      end
    end
    while (n < total && cyc < 1000) begin
      if (poke) begin
        start  = 1'($urandom);
        offset = W'($urandom);
        extent = (D*W)'({$urandom, $urandom});
        stride = (D*W)'({$urandom, $urandom});
      end
      addr_ready = (n == bp_at && hold < 3) ? 1'b0 : rnd_ready ? 1'($urandom) : 1'b1;
      if (n == bp_at && hold < 3) hold++;
      checks++;
      if (addr_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s status[%0d]: valid=%b busy=%b done=%b, want 1 1 0", name, n, addr_valid, busy, done);
      end
      checks++;
      if (addr_out !== exp_q[n] || addr_last !== (n == total - 1)) begin
        errors++;
        $display("FAIL %s addr[%0d]: addr=%h last=%b, want addr=%h last=%b", name, n, addr_out, addr_last, exp_q[n], n == total - 1);
      end
      if (addr_ready) n++;
      step();
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b0;
    if (cyc >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: accepted %0d, want %0d", name, n, total);
    end
    if (total > 0) begin
      checks++;
      if (addr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s end: valid=%b done=%b busy=%b, want 0 1 1", name, addr_valid, done, busy);
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: done=%b busy=%b valid=%b, want 0 0 0", name, done, busy, addr_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({addr_out, addr_valid, addr_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: addr=%h valid=%b last=%b busy=%b done=%b, want all 0", addr_out, addr_valid, addr_last, busy, done);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, addr_valid);
    end
  endtask

  task automatic test_basic_2d();
    m_off = 16'd100;
    m_ext = '{3, 2, 1};
    m_str = '{16'd1, 16'd10, 16'd0};
    walk("basic_2d", 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    m_off = 16'd100;
    m_ext = '{3, 2, 1};
    m_str = '{16'd1, 16'd10, 16'd0};
    walk("backpressure", 1'b0, 1'b0, 1);
  endtask

  task automatic test_3d();
    m_off = 16'd0;
    m_ext = '{2, 2, 2};
    m_str = '{16'd4, 16'hFFF9, 16'd100};
    walk("walk_3d", 1'b0, 1'b0, -1);
  endtask

  task automatic test_zero_extent();
    m_off = 16'h1234;
    m_ext = '{3, 0, 2};
    m_str = '{16'd1, 16'd2, 16'd3};
    walk("zero_extent", 1'b0, 1'b0, -1);
    m_off = 16'hBEEF;
    m_ext = '{1, 1, 1};
    walk("all_ones", 1'b0, 1'b0, -1);
  endtask

  task automatic test_control_corners();
    rand_cfg();
    walk("poke_run", 1'b1, 1'b1, -1);
    rand_cfg();
    m_ext = '{4, 3, 2};
    offset = m_off;
    for (int i = 0; i < D; i++) begin
      extent[i*W +: W] = W'(m_ext[i]);
      stride[i*W +: W] = m_str[i];
    end
    start = 1'b1;
    step();
    start = 1'b0;
    addr_ready = 1'b1;
    step();
    step();
    addr_ready = 1'b0;
    checks++;
    if (addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL midwalk_valid: valid=%b, want 1", addr_valid);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({addr_out, addr_valid, addr_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL midwalk_reset: addr=%h valid=%b last=%b busy=%b done=%b, want all 0", addr_out, addr_valid, addr_last, busy, done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abandon_no_done: done=%b busy=%b, want 0 0", done, busy);
      end
    end
    walk("restart", 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    rand_cfg();
    walk("b2b_first", 1'b1, 1'b0, -1);
    rand_cfg();
    walk("b2b_second", 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      rand_cfg();
      walk("random", 1'b1, 1'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_2d();
    test_backpressure();
    test_3d();
    test_zero_extent();
    test_control_corners();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
